// File: rtl/execute_alu_stage_pkg.sv
// Shared definitions for the execute ALU stage: opcode and condition
// encodings, NZCV bit positions and opcode classification helpers.
package execute_alu_stage_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Compare-class opcodes always set flags and never write back.
    function automatic logic is_compare(input opcode_e op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/execute_alu_stage_condition_tester.sv
// Combinational condition-code check of cond against the NZCV flags.
module condition_tester
    import execute_alu_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition field into a single pass/fail bit.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_alu_stage.sv
// Single-cycle execute stage: conditional data-processing ALU with an
// NZCV flags register and a one-entry valid/ready output register.
module execute_alu_stage
    import execute_alu_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [RD_W-1:0]   rd,
    input  logic [DATA_W-1:0] rn_val,
    input  logic [DATA_W-1:0] shifter_op,
    input  logic              shifter_c,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en,
    output logic [3:0]        flags
);

    opcode_e           op;
    logic              cond_pass;
    logic              accept;
    logic              compare_op;
    logic              arith;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              cin;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic [3:0]        next_flags;
    logic              flags_we;
    logic              wb_en;

    assign op         = opcode_e'(opcode);
    assign compare_op = is_compare(op);
    assign in_ready   = out_ready || !out_valid;
    assign accept     = in_valid && in_ready && !flush;

    condition_tester u_cond (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    // Operand selection: every subtract-style op is folded into a + ~b + cin.
    always_comb begin
        a_in      = rn_val;
        b_in      = shifter_op;
        cin       = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        case (op)
            OP_AND, OP_TST: logic_res = rn_val & shifter_op;
            OP_EOR, OP_TEQ: logic_res = rn_val ^ shifter_op;
            OP_ORR:         logic_res = rn_val | shifter_op;
            OP_MOV:         logic_res = shifter_op;
            OP_BIC:         logic_res = rn_val & ~shifter_op;
            OP_MVN:         logic_res = ~shifter_op;
            OP_SUB, OP_CMP: begin arith = 1'b1; b_in = ~shifter_op; cin = 1'b1; end
            OP_RSB:         begin arith = 1'b1; a_in = shifter_op; b_in = ~rn_val; cin = 1'b1; end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_ADC:         begin arith = 1'b1; cin = flags[FLAG_C]; end
            OP_SBC:         begin arith = 1'b1; b_in = ~shifter_op; cin = flags[FLAG_C]; end
            OP_RSC:         begin arith = 1'b1; a_in = shifter_op; b_in = ~rn_val; cin = flags[FLAG_C]; end
            default:        logic_res = '0;
        endcase
    end

    // Widened adder, result mux and the candidate NZCV value.
    always_comb begin
        sum    = {1'b0, a_in} + {1'b0, b_in} + {{DATA_W{1'b0}}, cin};
        result = arith ? sum[DATA_W-1:0] : logic_res;
        next_flags         = flags;
        next_flags[FLAG_N] = result[DATA_W-1];
        next_flags[FLAG_Z] = (result == '0);
        next_flags[FLAG_C] = arith ? sum[DATA_W] : shifter_c;
        if (arith) begin
            next_flags[FLAG_V] = (a_in[DATA_W-1] == b_in[DATA_W-1]) &&
                                 (result[DATA_W-1] != a_in[DATA_W-1]);
        end
        flags_we = cond_pass && (s_bit || compare_op);
        wb_en    = cond_pass && !compare_op;
    end

    // Output register and flags: reset, then flush, then accept, then drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wb_en  <= 1'b0;
            flags      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_rd     <= rd;
            out_wb_en  <= wb_en;
            if (flags_we) begin
                flags <= next_flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_alu_stage.sv
// Directed table-driven bench for execute_alu_stage plus hand-written
// backpressure and post-reset sequences.
module tb_execute_alu_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  rd;
    logic [31:0] rn_val;
    logic [31:0] shifter_op;
    logic        shifter_c;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wb_en;
    logic [3:0]  flags;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [3:0]  cnd;
        logic [3:0]  opc;
        logic        s;
        logic [3:0]  d;
        logic [31:0] rn;
        logic [31:0] op;
        logic        sc;
        logic        fl;
        logic        ev;
        logic [31:0] eres;
        logic [3:0]  erd;
        logic        ewb;
        logic [3:0]  ef;
    } vec_t;

    vec_t tbl[$];

    execute_alu_stage #(.DATA_W(32), .RD_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cond       (cond),
        .opcode     (opcode),
        .s_bit      (s_bit),
        .rd         (rd),
        .rn_val     (rn_val),
        .shifter_op (shifter_op),
        .shifter_c  (shifter_c),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic iv, input logic [3:0] cnd,
                                input logic [3:0] opc, input logic s, input logic [3:0] d,
                                input logic [31:0] rn, input logic [31:0] op, input logic sc,
                                input logic fl, input logic ev, input logic [31:0] eres,
                                input logic [3:0] erd, input logic ewb, input logic [3:0] ef);
        vec_t v;
        v.rst = rst; v.iv = iv; v.cnd = cnd; v.opc = opc; v.s = s; v.d = d;
        v.rn = rn; v.op = op; v.sc = sc; v.fl = fl;
        v.ev = ev; v.eres = eres; v.erd = erd; v.ewb = ewb; v.ef = ef;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset      = v.rst;
        in_valid   = v.iv;
        cond       = v.cnd;
        opcode     = v.opc;
        s_bit      = v.s;
        rd         = v.d;
        rn_val     = v.rn;
        shifter_op = v.op;
        shifter_c  = v.sc;
        flush      = v.fl;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [31:0] eres,
                             input logic [3:0] erd, input logic ewb, input logic [3:0] ef);
        n_vec++;
        if (out_valid !== ev || out_result !== eres || out_rd !== erd ||
            out_wb_en !== ewb || flags !== ef) begin
            n_err++;
            $display("FAIL %s: got v=%b res=%h rd=%h wb=%b nzcv=%b, expected v=%b res=%h rd=%h wb=%b nzcv=%b",
                     name, out_valid, out_result, out_rd, out_wb_en, flags,
                     ev, eres, erd, ewb, ef);
        end
    endtask

    task automatic check_ready(input string name, input logic exp);
        n_vec++;
        if (in_ready !== exp) begin
            n_err++;
            $display("FAIL %s: in_ready got %b, expected %b", name, in_ready, exp);
        end
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        out_ready = 1'b1;
        drive(mk(1, 0, 4'hE, 4'd0, 0, 4'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'd0, 0, 4'b0000));

        //          rst iv cond opc  s  rd   rn            op            sc fl  ev res           rd  wb nzcv
        tbl.push_back(mk(1, 0, 4'hE, 4'd0,  0, 4'd0, 32'h0,        32'h0,        0, 0,  0, 32'h0,        4'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd4,  1, 4'd1, 32'h7FFFFFFF, 32'h1,        0, 0,  1, 32'h80000000, 4'd1, 1, 4'b1001));
        tbl.push_back(mk(1, 1, 4'hE, 4'd4,  1, 4'd3, 32'h1,        32'h1,        0, 1,  0, 32'h0,        4'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd4,  1, 4'd1, 32'h7FFFFFFF, 32'h1,        0, 0,  1, 32'h80000000, 4'd1, 1, 4'b1001));
        tbl.push_back(mk(0, 1, 4'hE, 4'd13, 1, 4'd2, 32'h1234,     32'h0,        1, 0,  1, 32'h0,        4'd2, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'hE, 4'd4,  1, 4'd7, 32'h1,        32'h1,        0, 1,  0, 32'h0,        4'd2, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 4'hE, 4'd2,  1, 4'd3, 32'h5,        32'h5,        0, 0,  1, 32'h0,        4'd3, 1, 4'b0110));
        tbl.push_back(mk(0, 1, 4'hE, 4'd10, 0, 4'd4, 32'h3,        32'h5,        0, 0,  1, 32'hFFFFFFFE, 4'd4, 0, 4'b1000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd10, 0, 4'd5, 32'h7,        32'h7,        0, 0,  1, 32'h0,        4'd5, 0, 4'b0110));
        tbl.push_back(mk(0, 1, 4'h1, 4'd13, 0, 4'd6, 32'h0,        32'h9,        0, 0,  1, 32'h9,        4'd6, 0, 4'b0110));
        tbl.push_back(mk(0, 1, 4'h0, 4'd13, 0, 4'd6, 32'h0,        32'h9,        0, 0,  1, 32'h9,        4'd6, 1, 4'b0110));
        tbl.push_back(mk(0, 0, 4'hE, 4'd4,  1, 4'd9, 32'h1,        32'h1,        0, 0,  0, 32'h9,        4'd6, 1, 4'b0110));
        tbl.push_back(mk(0, 1, 4'hF, 4'd13, 1, 4'd7, 32'h0,        32'h55,       0, 0,  1, 32'h55,       4'd7, 0, 4'b0110));
        tbl.push_back(mk(0, 1, 4'hE, 4'd5,  1, 4'd7, 32'h1,        32'h1,        0, 0,  1, 32'h3,        4'd7, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd6,  1, 4'd8, 32'h5,        32'h3,        0, 0,  1, 32'h1,        4'd8, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 4'd3,  0, 4'd8, 32'h2,        32'hA,        0, 0,  1, 32'h8,        4'd8, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 4'hE, 4'd1,  1, 4'd9, 32'hF0F0F0F0, 32'hFFFF0000, 0, 0,  1, 32'h0F0FF0F0, 4'd9, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd14, 1, 4'd9, 32'hFFFFFFFF, 32'h0000FFFF, 1, 0,  1, 32'hFFFF0000, 4'd9, 1, 4'b1010));
        tbl.push_back(mk(0, 1, 4'hE, 4'd15, 0, 4'd10, 32'h0,       32'h0,        0, 0,  1, 32'hFFFFFFFF, 4'd10, 1, 4'b1010));
        tbl.push_back(mk(0, 1, 4'hE, 4'd9,  0, 4'd11, 32'hA,       32'hA,        0, 0,  1, 32'h0,        4'd11, 0, 4'b0100));
        tbl.push_back(mk(0, 1, 4'hE, 4'd11, 0, 4'd11, 32'hFFFFFFFF, 32'h1,       0, 0,  1, 32'h0,        4'd11, 0, 4'b0110));
        tbl.push_back(mk(0, 1, 4'hA, 4'd12, 1, 4'd12, 32'h80000000, 32'h1,       0, 0,  1, 32'h80000001, 4'd12, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 4'hB, 4'd13, 0, 4'd13, 32'h0,       32'h22,       0, 0,  1, 32'h22,       4'd13, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 4'hE, 4'd7,  1, 4'd14, 32'h1,       32'h5,        0, 0,  1, 32'h3,        4'd14, 1, 4'b0010));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eres, tbl[i].erd, tbl[i].ewb, tbl[i].ef);
        end

        // Backpressure: one result stuck for three cycles, then the waiting input drains in.
        @(negedge clk);
        drive(mk(0, 1, 4'hE, 4'd4, 0, 4'd9, 32'h1, 32'h2, 0, 0, 0, 32'h0, 4'd0, 0, 4'b0000));
        @(posedge clk);
        #1;
        check_out("stall_load", 1'b1, 32'h3, 4'd9, 1'b1, 4'b0010);
        @(negedge clk);
        drive(mk(0, 1, 4'hE, 4'd2, 1, 4'd10, 32'hA, 32'h4, 0, 0, 0, 32'h0, 4'd0, 0, 4'b0000));
        out_ready = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            check_ready($sformatf("stall_ready%0d", k), 1'b0);
            @(posedge clk);
            #1;
            check_out($sformatf("stall_hold%0d", k), 1'b1, 32'h3, 4'd9, 1'b1, 4'b0010);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check_ready("release_ready", 1'b1);
        @(posedge clk);
        #1;
        check_out("release_accept", 1'b1, 32'h6, 4'd10, 1'b1, 4'b0010);

        // Flush while stalled clears the held result without touching flags.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        check_out("flush_stalled", 1'b0, 32'h6, 4'd10, 1'b1, 4'b0010);

        // Reset, then in_ready must be high on the first cycle even with out_ready low.
        @(negedge clk);
        flush = 1'b0;
        v = mk(1, 1, 4'hE, 4'd4, 1, 4'd5, 32'h1, 32'h1, 0, 1, 0, 32'h0, 4'd0, 0, 4'b0000);
        drive(v);
        @(posedge clk);
        #1;
        check_out("reset_again", 1'b0, 32'h0, 4'd0, 1'b0, 4'b0000);
        @(negedge clk);
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_ready("post_reset_ready", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
